// File: rtl/arith_div_pkg.sv
// Shared types and constants for the sequential signed divider family.
package arith_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   // Fill bit of the divide-by-zero quotient (all ones, i.e. -1).
   localparam logic Q_DIV0_BIT = 1'b1;

   function automatic int cnt_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/s_seq_div_cska4_if.sv
// Operand/result handshake bundle of the sequential signed divider.
interface s_seq_div_cska4_if #(
   parameter int WIDTH = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] a;
   logic signed [WIDTH-1:0] b;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] q;
   logic signed [WIDTH-1:0] r;
   logic                    dz;
   logic                    ovf;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, q, r, dz, ovf
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, q, r, dz, ovf
   );
endinterface

// File: rtl/s_seq_div_cska4_sub.sv
// Carry-skip subtractor: a + ~b + 1, with the block carry bypassed when a whole block propagates.
module s_seq_div_cska4_sub #(
   parameter int W          = 5,
   parameter int SKIP_BLOCK = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow_n
);

   logic [W-1:0] bn_w;
   logic [W-1:0] p_w;
   logic [W-1:0] g_w;
   logic         c_w;
   logic         blk_c_w;
   logic         prop_w;

   assign bn_w = ~b;
   assign p_w  = a ^ bn_w;
   assign g_w  = a & bn_w;

   always_comb begin
      diff    = '0;
      c_w     = 1'b1;
      blk_c_w = 1'b1;
      prop_w  = 1'b1;
      for (int i = 0; i < W; i++) begin
         if (i % SKIP_BLOCK == 0) begin
            c_w    = blk_c_w;
            prop_w = 1'b1;
         end
         prop_w  = prop_w & p_w[i];
         diff[i] = p_w[i] ^ c_w;
         c_w     = g_w[i] | (p_w[i] & c_w);
         // Block carry-out skips the ripple chain when every bit propagates.
         if ((i % SKIP_BLOCK == SKIP_BLOCK - 1) || (i == W - 1)) begin
            blk_c_w = prop_w ? blk_c_w : c_w;
         end
      end
      borrow_n = blk_c_w;
   end

endmodule

// File: rtl/s_seq_div_cska4.sv
// Sequential signed radix-2 restoring divider, one quotient bit per cycle over a carry-skip subtractor.
module s_seq_div_cska4
   import arith_div_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int SKIP_BLOCK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   s_seq_div_cska4_if.slave  div
);

   localparam int MW    = WIDTH + 1;
   localparam int CNT_W = cnt_w(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [MW-1:0]      rem_q, rem_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [MW-1:0]      bmag_q, bmag_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic               sb_q, sb_d;
   logic               dzf_q, dzf_d;
   logic               ovff_q, ovff_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   r_q, r_d;
   logic               dz_q, dz_d;
   logic               ovf_q, ovf_d;
   logic               out_valid_q, out_valid_d;

   logic [MW-1:0]      shifted_w;
   logic [MW-1:0]      diff_w;
   logic               borrow_n_w;
   logic [WIDTH-1:0]   a_abs_w;
   logic [WIDTH-1:0]   b_abs_w;
   logic               sa_w;

   assign shifted_w = {rem_q[MW-2:0], dvd_q[WIDTH-1]};
   assign a_abs_w   = div.a[WIDTH-1] ? WIDTH'(-div.a) : div.a;
   assign b_abs_w   = div.b[WIDTH-1] ? WIDTH'(-div.b) : div.b;
   assign sa_w      = a_q[WIDTH-1];

   s_seq_div_cska4_sub #(
      .W          (MW),
      .SKIP_BLOCK (SKIP_BLOCK)
   ) u_cska_sub (
      .a        (shifted_w),
      .b        (bmag_q),
      .diff     (diff_w),
      .borrow_n (borrow_n_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         dvd_q       <= '0;
         bmag_q      <= '0;
         a_q         <= '0;
         sb_q        <= 1'b0;
         dzf_q       <= 1'b0;
         ovff_q      <= 1'b0;
         q_q         <= '0;
         r_q         <= '0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         dvd_q       <= dvd_d;
         bmag_q      <= bmag_d;
         a_q         <= a_d;
         sb_q        <= sb_d;
         dzf_q       <= dzf_d;
         ovff_q      <= ovff_d;
         q_q         <= q_d;
         r_q         <= r_d;
         dz_q        <= dz_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      dvd_d       = dvd_q;
      bmag_d      = bmag_q;
      a_d         = a_q;
      sb_d        = sb_q;
      dzf_d       = dzf_q;
      ovff_d      = ovff_q;
      q_d         = q_q;
      r_d         = r_q;
      dz_d        = dz_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         IDLE: begin
            if (div.in_valid) begin
               a_d     = div.a;
               sb_d    = div.b[WIDTH-1];
               dvd_d   = a_abs_w;
               bmag_d  = {1'b0, b_abs_w};
               rem_d   = '0;
               cnt_d   = CNT_W'(WIDTH - 1);
               dzf_d   = (div.b == '0);
               ovff_d  = (div.a == MIN_VAL) && (div.b == '1);
               state_d = ITER;
            end
         end
         ITER: begin
            // Restore by simply keeping the shifted remainder when the trial borrows.
            rem_d = borrow_n_w ? diff_w : shifted_w;
            dvd_d = {dvd_q[WIDTH-2:0], borrow_n_w};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (dzf_q) begin
               q_d = {WIDTH{Q_DIV0_BIT}};
               r_d = a_q;
            end else begin
               q_d = WIDTH'((sa_w ^ sb_q) ? -{1'b0, dvd_q} : {1'b0, dvd_q});
               r_d = WIDTH'(sa_w ? -rem_q : rem_q);
            end
            dz_d    = dzf_q;
            ovf_d   = ovff_q;
            state_d = DONE;
         end
         DONE: begin
            // Results land one cycle ahead of out_valid, so the first DONE cycle only raises it.
            if (out_valid_q && div.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign div.in_ready  = (state_q == IDLE);
   assign div.out_valid = out_valid_q;
   assign div.q         = q_q;
   assign div.r         = r_q;
   assign div.dz        = dz_q;
   assign div.ovf       = ovf_q;

endmodule

// File: tb/tb_s_seq_div_cska4.sv
// Self-checking bench for the sequential signed divider against an integer reference model.
module tb_s_seq_div_cska4;

   localparam int W   = 4;
   localparam int LAT = W + 2;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   s_seq_div_cska4_if #(.WIDTH(W)) dif ();

   s_seq_div_cska4 #(.WIDTH(W), .SKIP_BLOCK(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .div   (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Truncating division with the two special cases, in plain integer arithmetic.
   function automatic void model(input int av, input int bv, output logic [3:0] qe,
                                 output logic [3:0] re, output logic dze, output logic ovfe);
      int qi;
      int ri;
      qi = 0;
      ri = 0;
      if (bv == 0) begin
         qe = 4'hF; re = av[3:0]; dze = 1'b1; ovfe = 1'b0;
      end else if (av == -8 && bv == -1) begin
         qe = 4'b1000; re = 4'b0000; dze = 1'b0; ovfe = 1'b1;
      end else begin
         qi = av / bv;
         ri = av % bv;
         qe = qi[3:0]; re = ri[3:0]; dze = 1'b0; ovfe = 1'b0;
      end
   endfunction

   task automatic run_op(input int av, input int bv, input int stall,
                         output logic [3:0] qo, output logic [3:0] ro, output logic dzo,
                         output logic ovfo, output int lat, output bit to);
      int n;
      n   = 0;
      lat = 0;
      to  = 1'b0;
      while (!dif.in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!dif.in_ready) to = 1'b1;
      dif.a        = av[3:0];
      dif.b        = bv[3:0];
      dif.in_valid = 1'b1;
      @(posedge clk); #1;
      dif.in_valid = 1'b0;
      dif.a        = 4'($urandom);
      dif.b        = 4'($urandom);
      while (!dif.out_valid && lat < 40) begin
         @(posedge clk); lat++; #1;
      end
      if (!dif.out_valid) to = 1'b1;
      repeat (stall) @(posedge clk);
      #1;
      qo   = dif.q;
      ro   = dif.r;
      dzo  = dif.dz;
      ovfo = dif.ovf;
      dif.out_ready = 1'b1;
      @(posedge clk); #1;
      dif.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      dif.in_valid = 1'b0; dif.out_ready = 1'b0; dif.a = '0; dif.b = '0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({dif.in_ready, dif.out_valid, dif.q, dif.r, dif.dz, dif.ovf} !== {1'b1, 1'b0, 8'h00, 2'b00}) begin
         fails++;
         $display("FAIL reset: rdy=%b vld=%b q=%h r=%h dz=%b ovf=%b, required rdy=1 vld=0 q=0 r=0 dz=0 ovf=0",
                  dif.in_ready, dif.out_valid, dif.q, dif.r, dif.dz, dif.ovf);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_table();
      int tab[9][6] = '{
         '{ 7,  2,  3,  1, 0, 0}, '{-7,  2, -3, -1, 0, 0}, '{ 7, -2, -3,  1, 0, 0},
         '{-7, -2,  3, -1, 0, 0}, '{-8, -1, -8,  0, 0, 1}, '{ 5,  0, -1,  5, 1, 0},
         '{-8,  1, -8,  0, 0, 0}, '{ 0,  3,  0,  0, 0, 0}, '{-1,  0, -1, -1, 1, 0}};
      logic [3:0] qo, ro, qe, re;
      logic dzo, ovfo;
      int lat;
      bit to;
      for (int i = 0; i < 9; i++) begin
         run_op(tab[i][0], tab[i][1], i % 3, qo, ro, dzo, ovfo, lat, to);
         qe = 4'(tab[i][2]);
         re = 4'(tab[i][3]);
         tests++;
         if (to || {qo, ro, dzo, ovfo} !== {qe, re, tab[i][4] != 0, tab[i][5] != 0}) begin
            fails++;
            $display("FAIL directed %0d/%0d: q=%h r=%h dz=%b ovf=%b to=%b, required q=%h r=%h dz=%0d ovf=%0d",
                     tab[i][0], tab[i][1], qo, ro, dzo, ovfo, to, qe, re, tab[i][4], tab[i][5]);
         end
         tests++;
         if (lat !== LAT) begin
            fails++;
            $display("FAIL latency %0d/%0d: %0d edges, required %0d", tab[i][0], tab[i][1], lat, LAT);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      bit bad;
      n = 0;
      bad = 1'b0;
      dif.a = 4'd6; dif.b = 4'd4; dif.in_valid = 1'b1;
      @(posedge clk); #1;
      dif.in_valid = 1'b0;
      while (!dif.out_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      for (int i = 0; i < 10; i++) begin
         if (dif.q !== 4'd1 || dif.r !== 4'd2 || dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0) bad = 1'b1;
         @(posedge clk); #1;
      end
      tests++;
      if (bad || n >= 40) begin
         fails++;
         $display("FAIL backpressure hold: q=%h r=%h vld=%b rdy=%b, required q=1 r=2 vld=1 rdy=0",
                  dif.q, dif.r, dif.out_valid, dif.in_ready);
      end
      dif.out_ready = 1'b1;
      @(posedge clk); #1;
      dif.out_ready = 1'b0;
      tests++;
      if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || dif.q !== 4'd1 || dif.r !== 4'd2) begin
         fails++;
         $display("FAIL backpressure release: rdy=%b vld=%b q=%h r=%h, required rdy=1 vld=0 q=1 r=2",
                  dif.in_ready, dif.out_valid, dif.q, dif.r);
      end
   endtask

   task automatic test_busy_ignore();
      int n;
      n = 0;
      dif.a = 4'd7; dif.b = 4'd3; dif.in_valid = 1'b1;
      @(posedge clk); #1;
      dif.a = -4'sd5; dif.b = 4'd2;
      while (!dif.out_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      tests++;
      if (n >= 40 || dif.q !== 4'd2 || dif.r !== 4'd1) begin
         fails++;
         $display("FAIL busy_ignore: q=%h r=%h, required q=2 r=1", dif.q, dif.r);
      end
      dif.in_valid = 1'b0;
      dif.out_ready = 1'b1;
      @(posedge clk); #1;
      dif.out_ready = 1'b0;
   endtask

   task automatic test_reset_midop();
      logic [3:0] qo, ro;
      logic dzo, ovfo;
      int lat;
      bit to;
      bit seen;
      seen = 1'b0;
      dif.a = 4'($urandom_range(1, 7)); dif.b = 4'($urandom_range(1, 7)); dif.in_valid = 1'b1;
      @(posedge clk); #1;
      dif.in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({dif.in_ready, dif.out_valid, dif.q, dif.r, dif.dz, dif.ovf} !== {1'b1, 1'b0, 8'h00, 2'b00}) begin
         fails++;
         $display("FAIL reset_midop: rdy=%b vld=%b q=%h r=%h dz=%b ovf=%b, required rdy=1 vld=0 all zero",
                  dif.in_ready, dif.out_valid, dif.q, dif.r, dif.dz, dif.ovf);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (dif.out_valid) seen = 1'b1;
      end
      tests++;
      if (seen) begin
         fails++;
         $display("FAIL reset_abort: out_valid=1 after abort, required 0");
      end
      run_op(3, 3, 0, qo, ro, dzo, ovfo, lat, to);
      tests++;
      if (to || qo !== 4'd1 || ro !== 4'd0) begin
         fails++;
         $display("FAIL after_reset 3/3: q=%h r=%h to=%b, required q=1 r=0", qo, ro, to);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] qo, ro, qe, re;
      logic dzo, ovfo, dze, ovfe;
      int lat;
      bit to;
      for (int av = -8; av < 8; av++) begin
         for (int bv = -8; bv < 8; bv++) begin
            run_op(av, bv, int'($urandom_range(0, 3)), qo, ro, dzo, ovfo, lat, to);
            model(av, bv, qe, re, dze, ovfe);
            tests++;
            if (to || {qo, ro, dzo, ovfo} !== {qe, re, dze, ovfe} || lat !== LAT) begin
               fails++;
               $display("FAIL exhaustive %0d/%0d: q=%h r=%h dz=%b ovf=%b lat=%0d, required q=%h r=%h dz=%b ovf=%b lat=%0d",
                        av, bv, qo, ro, dzo, ovfo, lat, qe, re, dze, ovfe, LAT);
            end
            if (!dze && !ovfe) begin
               tests++;
               if (int'($signed(qo)) * bv + int'($signed(ro)) != av) begin
                  fails++;
                  $display("FAIL identity %0d/%0d: q*b+r=%0d, required %0d",
                           av, bv, int'($signed(qo)) * bv + int'($signed(ro)), av);
               end
            end
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      dif.in_valid = 1'b0; dif.out_ready = 1'b0; dif.a = '0; dif.b = '0;
      test_reset();
      test_table();
      test_backpressure();
      test_busy_ignore();
      test_reset_midop();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
